// File: rtl/attn_pkg.sv
// Shared definitions for the attention stream I/O block: default widths,
// operand/result word counts and the load/run/drain state encoding.
package attn_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int N_IN_DEF    = 32;
    localparam int N_OUT_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } attn_state_e;

    // Key, query and value buses are loaded back to back from one stream.
    function automatic int operandWords(input int nIn);
        return 3 * nIn;
    endfunction

endpackage

// File: rtl/attn_watchdog.sv
// RUN-phase watchdog: counts enabled cycles from zero and flags expiry once
// the count reaches TIMEOUT; clear holds the count at zero.
module attn_watchdog
    import attn_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;

    // Count saturates at TIMEOUT so expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CW'(TIMEOUT))) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expire_o = enable_i && (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/attn_stream_io.sv
// Stream front-end for the attention PE array: loads key/query/value words,
// runs the array, then streams the captured result words back out.
// Optional RUN watchdog is enabled by defining ATTN_IO_WATCHDOG_EN.
module attn_stream_io
    import attn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    output logic [N_IN*DATA_W-1:0]  key_o,
    output logic [N_IN*DATA_W-1:0]  query_o,
    output logic [N_IN*DATA_W-1:0]  value_o,
    output logic                    pe_en,
    output logic                    pe_rst_n,
    input  logic [N_OUT*DATA_W-1:0] final_res_i,
    input  logic                    all_done_i,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int NWORDS = operandWords(N_IN);
    localparam int KW     = $clog2(NWORDS);
    localparam int JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    attn_state_e              state_q, state_d;
    logic [KW-1:0]            k_q;
    logic [JW-1:0]            j_q;
    logic [N_IN*DATA_W-1:0]   key_q, query_q, value_q;
    logic [N_OUT*DATA_W-1:0]  res_q;
    logic                     inBeat, outBeat, lastIn, lastOut, wdExpire;

    assign inBeat  = s_valid && (state_q == LOAD);
    assign outBeat = m_ready && (state_q == DRAIN);
    assign lastIn  = (k_q == KW'(NWORDS - 1));
    assign lastOut = (j_q == JW'(N_OUT - 1));

`ifdef ATTN_IO_WATCHDOG_EN
    logic timeoutErr_q;

    attn_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != RUN),
        .enable_i (state_q == RUN),
        .expire_o (wdExpire)
    );

    // A completion arriving on the expiry cycle wins, so no error then.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutErr_q <= 1'b0;
        end else if ((state_q == RUN) && wdExpire && !all_done_i) begin
            timeoutErr_q <= 1'b1;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign wdExpire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (inBeat && lastIn) state_d = RUN;
            RUN: begin
                if (all_done_i) begin
                    state_d = DRAIN;
                end else if (wdExpire) begin
                    state_d = LOAD;
                end
            end
            DRAIN:   if (outBeat && lastOut) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Operand buses are only written in LOAD, so they hold through RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            j_q     <= '0;
            key_q   <= '0;
            query_q <= '0;
            value_q <= '0;
            res_q   <= '0;
        end else begin
            if (inBeat) begin
                k_q <= lastIn ? '0 : k_q + KW'(1);
                for (int i = 0; i < N_IN; i++) begin
                    if (k_q == KW'(i))            key_q[i*DATA_W +: DATA_W]   <= s_data;
                    if (k_q == KW'(N_IN + i))     query_q[i*DATA_W +: DATA_W] <= s_data;
                    if (k_q == KW'(2 * N_IN + i)) value_q[i*DATA_W +: DATA_W] <= s_data;
                end
            end
            if ((state_q == RUN) && all_done_i) begin
                res_q <= final_res_i;
            end
            if (outBeat) begin
                j_q <= lastOut ? '0 : j_q + JW'(1);
            end
        end
    end

    always_comb begin
        s_ready  = (state_q == LOAD);
        pe_en    = (state_q == RUN);
        pe_rst_n = (state_q != LOAD);
        busy     = (state_q != LOAD);
        m_valid  = (state_q == DRAIN);
        m_last   = (state_q == DRAIN) && lastOut;
        m_data   = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if ((state_q == DRAIN) && (j_q == JW'(i))) begin
                m_data = res_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign key_o   = key_q;
    assign query_o = query_q;
    assign value_o = value_q;

endmodule

// File: tb/tb_attn_stream_io.sv
// Directed self-checking bench for attn_stream_io with default parameters;
// the timeout tests follow whether ATTN_IO_WATCHDOG_EN is defined.
module tb_attn_stream_io;

    localparam int DW = 16;
    localparam int NI = 32;
    localparam int NO = 16;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid, s_ready;
    logic [DW-1:0]    s_data;
    logic [NI*DW-1:0] key_o, query_o, value_o;
    logic             pe_en, pe_rst_n;
    logic [NO*DW-1:0] final_res_i;
    logic             all_done_i;
    logic             m_valid, m_ready, m_last;
    logic [DW-1:0]    m_data;
    logic             busy, timeout_err;

    int checks = 0;
    int errors = 0;

    attn_stream_io #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .key_o       (key_o),
        .query_o     (query_o),
        .value_o     (value_o),
        .pe_en       (pe_en),
        .pe_rst_n    (pe_rst_n),
        .final_res_i (final_res_i),
        .all_done_i  (all_done_i),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout got=hung exp=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called and returns at a falling edge; streams `beats` operand words.
    task automatic applyStimulus(input logic [15:0] kb, input logic [15:0] qb,
                                 input logic [15:0] vb, input int beats, input logic holdValid);
        for (int i = 0; i < beats; i++) begin
            s_valid = 1'b1;
            if (i < NI)          s_data = kb + 16'(i);
            else if (i < 2 * NI) s_data = qb + 16'(i - NI);
            else                 s_data = vb + 16'(i - 2 * NI);
            @(negedge clk);
        end
        s_valid = holdValid;
        s_data  = 16'hDEAD;
    endtask

    task automatic checkLoaded(input logic [15:0] kb, input logic [15:0] qb, input logic [15:0] vb);
        checkOutput("runBusy",    64'(busy),    64'd1);
        checkOutput("runSReady",  64'(s_ready), 64'd0);
        checkOutput("runPeEn",    64'(pe_en),   64'd1);
        checkOutput("runPeRstN",  64'(pe_rst_n), 64'd1);
        checkOutput("keyFirst",   64'(key_o[15:0]),      64'(kb));
        checkOutput("keyLast",    64'(key_o[511:496]),   64'(kb + 16'd31));
        checkOutput("queryFirst", 64'(query_o[15:0]),    64'(qb));
        checkOutput("valueLast",  64'(value_o[511:496]), 64'(vb + 16'd31));
    endtask

    // Entered on RUN cycle 0; raises all_done_i during RUN cycle n-1.
    task automatic runUntilDone(input int n, input logic [15:0] rb);
        for (int j = 0; j < NO; j++) final_res_i[j*DW +: DW] = rb + 16'(j);
        for (int i = 0; i < n - 1; i++) @(negedge clk);
        checkOutput("runStillRunning", 64'(pe_en), 64'd1);
        all_done_i = 1'b1;
        @(negedge clk);
        all_done_i  = 1'b0;
        final_res_i = '0;
        checkOutput("drainValid",   64'(m_valid),  64'd1);
        checkOutput("drainPeEn",    64'(pe_en),    64'd0);
        checkOutput("drainPeRstN",  64'(pe_rst_n), 64'd1);
        checkOutput("drainBusy",    64'(busy),     64'd1);
    endtask

    task automatic drainResults(input logic [15:0] rb, input logic toggle, input logic [15:0] kb);
        int n = 0;
        checkOutput("drainKeyHeld", 64'(key_o[15:0]), 64'(kb));
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!m_valid) break;
            m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            checkOutput("drainSReady", 64'(s_ready), 64'd0);
            checkOutput("drainData", 64'(m_data), 64'(rb + 16'(n)));
            checkOutput("drainLast", 64'(m_last), 64'(n == NO - 1));
            if (m_ready) n++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        checkOutput("drainBeats", 64'(n), 64'(NO));
        checkOutput("backToLoad", 64'(busy), 64'd0);
        checkOutput("loadSReady", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int runCycles;
        logic sawValid;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        all_done_i = 1'b0; final_res_i = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstSReady",  64'(s_ready),  64'd1);
        checkOutput("rstMValid",  64'(m_valid),  64'd0);
        checkOutput("rstMLast",   64'(m_last),   64'd0);
        checkOutput("rstMData",   64'(m_data),   64'd0);
        checkOutput("rstPeEn",    64'(pe_en),    64'd0);
        checkOutput("rstPeRstN",  64'(pe_rst_n), 64'd0);
        checkOutput("rstBusy",    64'(busy),     64'd0);
        checkOutput("rstTimeout", 64'(timeout_err), 64'd0);
        checkOutput("rstKey",     64'(key_o[63:0]), 64'd0);
        rst = 1'b0;

        // all_done_i while loading must not start anything
        all_done_i = 1'b1;
        @(negedge clk);
        all_done_i = 1'b0;
        checkOutput("doneInLoadBusy", 64'(busy), 64'd0);

        $display("[TB] basic load, run, full-rate drain");
        applyStimulus(16'h0001, 16'h0101, 16'h0201, 3 * NI, 1'b0);
        checkLoaded(16'h0001, 16'h0101, 16'h0201);
        runUntilDone(40, 16'hA000);
        drainResults(16'hA000, 1'b0, 16'h0001);

        $display("[TB] drain with m_ready toggling");
        applyStimulus(16'h1001, 16'h1101, 16'h1201, 3 * NI, 1'b0);
        checkLoaded(16'h1001, 16'h1101, 16'h1201);
        runUntilDone(5, 16'hB000);
        drainResults(16'hB000, 1'b1, 16'h1001);

        $display("[TB] reset in the middle of a load");
        applyStimulus(16'h2001, 16'h2101, 16'h2201, 50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstSReady", 64'(s_ready), 64'd1);
        checkOutput("midRstBusy",   64'(busy),    64'd0);
        checkOutput("midRstKey",    64'(key_o[15:0]), 64'd0);
        applyStimulus(16'h0301, 16'h0401, 16'h0501, 3 * NI, 1'b1);
        checkLoaded(16'h0301, 16'h0401, 16'h0501);

        $display("[TB] s_valid held through RUN and DRAIN");
        runUntilDone(3, 16'hC000);
        checkOutput("heldValidValue", 64'(value_o[511:496]), 64'h0520);
        drainResults(16'hC000, 1'b0, 16'h0301);
        applyStimulus(16'h3001, 16'h3101, 16'h3201, 3 * NI, 1'b0);
        checkLoaded(16'h3001, 16'h3101, 16'h3201);

`ifdef ATTN_IO_WATCHDOG_EN
        $display("[TB] completion on the expiry cycle wins");
        runUntilDone(TO + 1, 16'hD000);
        checkOutput("tieNoError", 64'(timeout_err), 64'd0);
        drainResults(16'hD000, 1'b0, 16'h3001);

        $display("[TB] watchdog abort");
        applyStimulus(16'h4001, 16'h4101, 16'h4201, 3 * NI, 1'b0);
        runCycles = 0;
        sawValid  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            if (m_valid) sawValid = 1'b1;
            runCycles++;
            @(negedge clk);
        end
        checkOutput("wdRunCycles", 64'(runCycles), 64'(TO + 1));
        checkOutput("wdErr",       64'(timeout_err), 64'd1);
        checkOutput("wdNoDrain",   64'(sawValid), 64'd0);
        checkOutput("wdSReady",    64'(s_ready), 64'd1);
        applyStimulus(16'h5001, 16'h5101, 16'h5201, 3 * NI, 1'b0);
        runUntilDone(4, 16'hE000);
        drainResults(16'hE000, 1'b0, 16'h5001);
        checkOutput("wdErrSticky", 64'(timeout_err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("wdErrCleared", 64'(timeout_err), 64'd0);
`else
        $display("[TB] no watchdog: RUN waits for completion");
        for (int i = 0; i < TO + 50; i++) @(negedge clk);
        checkOutput("noWdBusy", 64'(busy), 64'd1);
        checkOutput("noWdErr",  64'(timeout_err), 64'd0);
        runUntilDone(1, 16'hD000);
        drainResults(16'hD000, 1'b0, 16'h3001);
        checkOutput("noWdErrAfter", 64'(timeout_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
